// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: tags each ALU result with Z/N/C/V/P flags, queues up to two results
// in order, and retires them into the architectural flags register.
module alu_wb_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_aluctrl,
    input  logic [DATA_W-1:0]  in_din1,
    input  logic [DATA_W-1:0]  in_din2,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_wen,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_wen,
    output logic [4:0]         out_flags,
    output logic [4:0]         flags_q
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_MV  = 4'b1000;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [RADDR_W-1:0] rd;
        logic               wen;
        logic [4:0]         flags;
        logic               upd;
    } ent_t;

    ent_t              in_ent;
    logic [DATA_W:0]   sum;
    logic [2*DATA_W-1:0] prod;
    logic              flag_c;
    logic              flag_v;

    always_comb begin
        sum    = {1'b0, in_din1} + {1'b0, in_din2};
        prod   = {{DATA_W{1'b0}}, in_din1} * {{DATA_W{1'b0}}, in_din2};
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (in_aluctrl)
            OP_ADD: begin
                flag_c = sum[DATA_W];
                flag_v = (in_din1[DATA_W-1] == in_din2[DATA_W-1]) &&
                         (in_result[DATA_W-1] != in_din1[DATA_W-1]);
            end
            OP_SUB: begin
                flag_c = (in_din1 < in_din2);
                flag_v = (in_din1[DATA_W-1] != in_din2[DATA_W-1]) &&
                         (in_result[DATA_W-1] != in_din1[DATA_W-1]);
            end
            OP_MUL: begin
                flag_c = |prod[2*DATA_W-1:DATA_W];
                flag_v = flag_c;
            end
            default: ;
        endcase
        in_ent.result = in_result;
        in_ent.rd     = in_rd;
        in_ent.wen    = in_wen;
        in_ent.flags  = {(in_result == '0), in_result[DATA_W-1], flag_c, flag_v, ^in_result};
        // Only real opcodes other than mv touch the architectural flags.
        in_ent.upd    = (in_aluctrl >= 4'd1) && (in_aluctrl <= 4'd13) && (in_aluctrl != OP_MV);
    end

    ent_t       mem_q [2];
    ent_t       mem_d [2];
    ent_t       out_q;
    ent_t       out_d;
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [4:0] flags_d;
    logic       in_acc;
    logic       out_ret;

    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_result = out_q.result;
    assign out_rd     = out_q.rd;
    assign out_wen    = out_q.wen;
    assign out_flags  = out_q.flags;

    always_comb begin
        in_acc  = in_valid & in_ready;
        out_ret = out_valid & out_ready;
        mem_d   = mem_q;
        out_d   = out_q;
        flags_d = flags_q;
        head_d  = head_q ^ out_ret;
        tail_d  = tail_q ^ in_acc;
        count_d = count_q + {1'b0, in_acc} - {1'b0, out_ret};
        if (in_acc) begin
            mem_d[tail_q] = in_ent;
        end
        // Output registers mirror the next head so there is no comb path from storage; empty holds.
        if (count_d != 2'd0) begin
            out_d = (in_acc && (head_d == tail_q)) ? in_ent : mem_q[head_d];
        end
        if (out_ret && out_q.upd) begin
            flags_d = out_q.flags;
        end
        if (flush) begin
            mem_d   = mem_q;
            out_d   = out_q;
            flags_d = flags_q;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            out_q    <= '0;
            flags_q  <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule
